// File: rtl/wordline_decoder.sv
// ---------------------------------------------------------------------------
// wordline_decoder
//   Pipelined ADDR_W-to-2**ADDR_W one-hot (or one-cold) SRAM wordline select
//   with pipeline stall, optional predecode stage and a built-in sweep
//   sequencer that walks every address once for self-test.
//
// Parameters
//   ADDR_W      address width, 2..8
//   PIPE        1 = direct decode, 2 = predecode + final AND
//   ACTIVE_LOW  1 = selected Z bit is 0 and idle Z is all ones
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active high
//   en           pipeline enable, 0 freezes every register
//   in_valid     A carries a request this cycle
//   A            address to decode
//   sweep_start  pulse: walk addresses 0..OUT_W-1
//   Z            registered wordline select
//   out_valid    Z carries a selected address
//   out_addr     address shown on Z
//   sweep_busy   sweep (issue or drain) in progress
//   sweep_done   pulse while the last sweep address is on Z
// ---------------------------------------------------------------------------
module wordline_decoder #(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned PIPE       = 2,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [ADDR_W-1:0]      A,
   input  logic                   sweep_start,
   output logic [(1<<ADDR_W)-1:0] Z,
   output logic                   out_valid,
   output logic [ADDR_W-1:0]      out_addr,
   output logic                   sweep_busy,
   output logic                   sweep_done
);

   localparam int unsigned        OUT_W     = 1 << ADDR_W;
   localparam int unsigned        LO_W      = ADDR_W / 2;
   localparam int unsigned        HI_W      = ADDR_W - LO_W;
   localparam int unsigned        LO_N      = 1 << LO_W;
   localparam int unsigned        HI_N      = 1 << HI_W;
   localparam logic [OUT_W-1:0]   IDLE_Z    = {OUT_W{ACTIVE_LOW}};
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(OUT_W - 1);

   // Reject unsupported configurations at elaboration
   if (ADDR_W < 2 || ADDR_W > 8 || (PIPE != 1 && PIPE != 2)) begin : g_bad_cfg
      $error("wordline_decoder: illegal configuration ADDR_W=%0d PIPE=%0d", ADDR_W, PIPE);
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                sweep_busy_q;

   logic                issue_c;
   logic [ADDR_W-1:0]   issue_addr_c;
   logic                issue_last_c;

   logic [OUT_W-1:0]    z_q, z_d;
   logic                out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic                sweep_done_q, sweep_done_d;

   // Issue-source selection and sweep sequencing
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      issue_c      = 1'b0;
      issue_addr_c = A;
      issue_last_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A simultaneous request is dropped in favour of the sweep
            if (sweep_start) begin
               state_d = S_SWEEP;
               cnt_d   = '0;
            end else if (in_valid) begin
               issue_c = 1'b1;
            end
         end
         S_SWEEP: begin
            issue_c      = 1'b1;
            issue_addr_c = cnt_q;
            cnt_d        = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
               issue_last_c = 1'b1;
               state_d      = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // sweep_done_q marks the cycle the last address sits on Z
            if (sweep_done_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sweep_busy_q <= 1'b0;
      end else if (en) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sweep_busy_q <= (state_d != S_IDLE);
      end
   end

   if (PIPE == 1) begin : g_direct
      // Single-stage full decode
      always_comb begin
         z_d          = IDLE_Z;
         out_valid_d  = issue_c;
         out_addr_d   = out_addr_q;
         sweep_done_d = 1'b0;
         if (issue_c) begin
            z_d          = (OUT_W'(1) << issue_addr_c) ^ IDLE_Z;
            out_addr_d   = issue_addr_c;
            sweep_done_d = issue_last_c;
         end
      end
   end else begin : g_predecode
      logic              s1_valid_q;
      logic              s1_last_q;
      logic [ADDR_W-1:0] s1_addr_q;
      logic [LO_N-1:0]   lo_pd_q;
      logic [HI_N-1:0]   hi_pd_q;
      logic [OUT_W-1:0]  z_and_c;

      // Stage 1: one-hot predecode of the low and high address fields
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            lo_pd_q    <= '0;
            hi_pd_q    <= '0;
         end else if (en) begin
            s1_valid_q <= issue_c;
            s1_last_q  <= issue_c & issue_last_c;
            s1_addr_q  <= issue_addr_c;
            lo_pd_q    <= LO_N'(1) << issue_addr_c[LO_W-1:0];
            hi_pd_q    <= HI_N'(1) << issue_addr_c[ADDR_W-1:LO_W];
         end
      end

      // Stage 2: final AND of the two predecoded groups
      for (genvar i = 0; i < OUT_W; i++) begin : g_and
         assign z_and_c[i] = lo_pd_q[i % LO_N] & hi_pd_q[i / LO_N];
      end

      always_comb begin
         z_d          = IDLE_Z;
         out_valid_d  = s1_valid_q;
         out_addr_d   = out_addr_q;
         sweep_done_d = 1'b0;
         if (s1_valid_q) begin
            z_d          = z_and_c ^ IDLE_Z;
            out_addr_d   = s1_addr_q;
            sweep_done_d = s1_last_q;
         end
      end
   end

   // Output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_q          <= IDLE_Z;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         sweep_done_q <= 1'b0;
      end else if (en) begin
         z_q          <= z_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign Z          = z_q;
   assign out_valid  = out_valid_q;
   assign out_addr   = out_addr_q;
   assign sweep_busy = sweep_busy_q;
   assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_wordline_decoder.sv
// Scoreboard bench: two ADDR_W=4/PIPE=2 decoders (active-high and active-low)
// share stimulus, plus an ADDR_W=6/PIPE=1 decoder on its own address bus.
module tb_wordline_decoder;

   localparam int unsigned AW  = 4;
   localparam int unsigned OW  = 16;
   localparam int unsigned AWC = 6;
   localparam int unsigned OWC = 64;

   logic clk = 1'b0;
   logic rst, en, in_valid, sweep_start, sweep_start_c;
   logic [AW-1:0]  a4;
   logic [AWC-1:0] a6;

   logic [OW-1:0]  z_a, z_b;
   logic [OWC-1:0] z_c;
   logic           v_a, v_b, v_c;
   logic [AW-1:0]  oa_a, oa_b;
   logic [AWC-1:0] oa_c;
   logic           busy_a, busy_b, busy_c;
   logic           done_a, done_b, done_c;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   wordline_decoder #(.ADDR_W(4), .PIPE(2), .ACTIVE_LOW(1'b0)) u_a (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .A(a4),
      .sweep_start(sweep_start), .Z(z_a), .out_valid(v_a), .out_addr(oa_a),
      .sweep_busy(busy_a), .sweep_done(done_a));

   wordline_decoder #(.ADDR_W(4), .PIPE(2), .ACTIVE_LOW(1'b1)) u_b (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .A(a4),
      .sweep_start(sweep_start), .Z(z_b), .out_valid(v_b), .out_addr(oa_b),
      .sweep_busy(busy_b), .sweep_done(done_b));

   wordline_decoder #(.ADDR_W(6), .PIPE(1), .ACTIVE_LOW(1'b0)) u_c (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .A(a6),
      .sweep_start(sweep_start_c), .Z(z_c), .out_valid(v_c), .out_addr(oa_c),
      .sweep_busy(busy_c), .sweep_done(done_c));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected wordline words, tagged with the enabled
   // cycle on which they must appear on the outputs.
   typedef struct {
      int due;
      int addr;
      bit last;
   } exp_t;

   exp_t q_ab[$];
   exp_t q_c[$];
   int   ecyc;
   bit   en_edge;
   int   mode;       // 0 idle, 1 issuing sweep, 2 waiting for last word
   int   sidx;
   int   last_due;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ecyc = 0; en_edge = 1'b0; mode = 0; sidx = 0; last_due = -10;
         q_ab.delete();
         q_c.delete();
      end else begin
         en_edge = en;
         if (en) begin
            ecyc++;
            if (mode == 0) begin
               if (sweep_start) begin
                  mode = 1;
                  sidx = 0;
               end else if (in_valid) begin
                  q_ab.push_back('{ecyc + 1, int'(a4), 1'b0});
               end
            end else if (mode == 1) begin
               q_ab.push_back('{ecyc + 1, sidx, sidx == OW - 1});
               if (sidx == OW - 1) begin
                  mode = 2;
                  last_due = ecyc + 1;
               end
               sidx++;
            end else if (ecyc == last_due + 1) begin
               mode = 0;
            end
            if (in_valid) q_c.push_back('{ecyc, int'(a6), 1'b0});
         end
      end
   end

   // Monitor: pops due entries and compares every output on the falling edge
   bit           ev, ed, ev_c;
   int           ea, ea_c;
   logic [OW-1:0]  exp_z, exp_zb;
   logic [OWC-1:0] exp_zc;
   exp_t         it;

   always @(negedge clk) begin
      if (rst) begin
         ev = 1'b0; ed = 1'b0; ea = 0; ev_c = 1'b0; ea_c = 0;
      end else begin
         if (en_edge) begin
            ev = 1'b0; ed = 1'b0; ev_c = 1'b0;
            if (q_ab.size() > 0 && q_ab[0].due == ecyc) begin
               it = q_ab.pop_front();
               ev = 1'b1; ea = it.addr; ed = it.last;
            end
            if (q_c.size() > 0 && q_c[0].due == ecyc) begin
               it = q_c.pop_front();
               ev_c = 1'b1; ea_c = it.addr;
            end
         end
         exp_z  = ev ? (OW'(1) << ea) : '0;
         exp_zb = ~exp_z;
         exp_zc = ev_c ? (OWC'(1) << ea_c) : '0;
         chk("z_a", 64'(z_a), 64'(exp_z));
         chk("z_b_active_low", 64'(z_b), 64'(exp_zb));
         chk("valid_a", 64'(v_a), 64'(ev));
         chk("valid_b", 64'(v_b), 64'(ev));
         chk("done_a", 64'(done_a), 64'(ev & ed));
         chk("done_b", 64'(done_b), 64'(ev & ed));
         chk("busy_a", 64'(busy_a), 64'(mode != 0));
         chk("busy_b", 64'(busy_b), 64'(mode != 0));
         if (ev) begin
            chk("addr_a", 64'(oa_a), 64'(ea));
            chk("addr_b", 64'(oa_b), 64'(ea));
         end
         chk("z_c", z_c, exp_zc);
         chk("valid_c", 64'(v_c), 64'(ev_c));
         if (ev_c) chk("addr_c", 64'(oa_c), 64'(ea_c));
         chk("busy_c", 64'(busy_c), 64'(0));
      end
   end

   task automatic drive(input bit iv, input int av, input int av6, input bit ss, input bit e);
      @(negedge clk);
      #1;
      in_valid    = iv;
      a4          = AW'(av);
      a6          = AWC'(av6);
      sweep_start = ss;
      en          = e;
   endtask

   task automatic check_reset();
      chk("rst_z_a", 64'(z_a), 64'h0);
      chk("rst_z_b", 64'(z_b), 64'hFFFF);
      chk("rst_z_c", z_c, 64'h0);
      chk("rst_valid", 64'({v_a, v_b, v_c}), 64'h0);
      chk("rst_addr", 64'({oa_a, oa_b, oa_c}), 64'h0);
      chk("rst_busy", 64'({busy_a, busy_b, busy_c}), 64'h0);
      chk("rst_done", 64'({done_a, done_b, done_c}), 64'h0);
   endtask

   // Keeps issuing random requests (which a busy sweep must ignore) until idle
   task automatic wait_idle();
      int budget = 200;
      do begin
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 63)), 1'b0, 1'b1);
         budget--;
      end while (busy_a && budget > 0);
      if (busy_a) chk("sweep_timeout", 64'(busy_a), 64'h0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
      sweep_start_c = 1'b0; a4 = '0; a6 = '0;
      #1;
      check_reset();
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;

      // Back-to-back addresses 0..15
      for (int i = 0; i < 16; i++) drive(1'b1, i, i * 4 + 3, 1'b0, 1'b1);
      repeat (4) drive(1'b0, 0, 0, 1'b0, 1'b1);

      // Isolated request: A=5 on the 4-bit parts, A=63 on the 6-bit part
      drive(1'b1, 5, 63, 1'b0, 1'b1);
      repeat (4) drive(1'b0, 0, 0, 1'b0, 1'b1);

      // Random traffic with stalls and occasional sweeps
      repeat (300)
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 63)), 1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 9) != 0));
      wait_idle();

      // Sweep start collides with a request; stall for 3 cycles mid-sweep
      drive(1'b1, 9, 1, 1'b1, 1'b1);
      repeat (5) drive(1'b1, int'($urandom_range(0, 15)), 2, 1'b0, 1'b1);
      repeat (3) drive(1'b1, int'($urandom_range(0, 15)), 3, 1'b0, 1'b0);
      wait_idle();
      repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a sweep
      drive(1'b0, 0, 0, 1'b1, 1'b1);
      repeat (6) drive(1'b0, 0, 0, 1'b0, 1'b1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (20) drive(1'b0, 0, 0, 1'b0, 1'b1);
      drive(1'b1, 3, 10, 1'b0, 1'b1);
      repeat (4) drive(1'b0, 0, 0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
